// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one usart transmit path between NREQ byte-stream
// requesters, with per-message channel locking and a stalled-owner lock timeout.
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int LOCK_TIMEOUT = 1024,
    localparam int OW          = $clog2(NREQ),
    localparam int CW          = $clog2(LOCK_TIMEOUT + 1)
) (
    input  logic              CLK50M,
    input  logic              RST,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ-1:0]   REQ_LAST,
    input  logic [8*NREQ-1:0] REQ_DATA,
    output logic [NREQ-1:0]   REQ_ACK,
    output logic [7:0]        TX_DATA,
    output logic              TX_WR,
    input  logic              TX_RDY,
    output logic [OW-1:0]     OWNER,
    output logic              LOCKED,
    output logic              BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LOW  = 2'd1,
        ST_WAIT_HIGH = 2'd2
    } state_t;

    state_t          state_r;
    logic [OW-1:0]   ptr_r;
    logic [CW-1:0]   cnt_r;

    logic [NREQ-1:0] owner_mask_s;
    logic [NREQ-1:0] eligible_s;
    logic [NREQ-1:0] ack_s;
    logic [OW-1:0]   winner_s;
    logic            found_s;
    logic            stall_s;
    logic            timeout_s;

    assign BUSY      = (state_r != ST_IDLE);
    assign stall_s   = LOCKED & ~REQ[OWNER];
    assign timeout_s = (cnt_r == CW'(LOCK_TIMEOUT - 1));

    // Eligibility mask: only the owner may be served while the channel is locked.
    always_comb begin
        owner_mask_s        = {NREQ{1'b0}};
        owner_mask_s[OWNER] = 1'b1;
        if (LOCKED) begin
            eligible_s = REQ & owner_mask_s;
        end else begin
            eligible_s = REQ;
        end
    end

    // Round-robin search starting one past the last winner.
    always_comb begin
        winner_s = {OW{1'b0}};
        found_s  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            winner_s = (!found_s && eligible_s[(int'(ptr_r) + k) % NREQ])
                       ? OW'((int'(ptr_r) + k) % NREQ) : winner_s;
            found_s  = found_s | eligible_s[(int'(ptr_r) + k) % NREQ];
        end
    end

    // One-hot acknowledge for the selected winner.
    always_comb begin
        ack_s           = {NREQ{1'b0}};
        ack_s[winner_s] = 1'b1;
    end

    // Grant FSM with registered strobes, ownership/lock tracking and lock timeout.
    always_ff @(posedge CLK50M) begin
        if (RST) begin
            state_r <= ST_IDLE;
            ptr_r   <= OW'(NREQ - 1);
            cnt_r   <= {CW{1'b0}};
            TX_DATA <= 8'h00;
            TX_WR   <= 1'b0;
            REQ_ACK <= {NREQ{1'b0}};
            OWNER   <= {OW{1'b0}};
            LOCKED  <= 1'b0;
        end else begin
            TX_WR   <= 1'b0;
            REQ_ACK <= {NREQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (TX_RDY && found_s) begin
                        TX_DATA <= REQ_DATA[8*winner_s +: 8];
                        TX_WR   <= 1'b1;
                        REQ_ACK <= ack_s;
                        OWNER   <= winner_s;
                        ptr_r   <= winner_s;
                        LOCKED  <= ~REQ_LAST[winner_s];
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_WAIT_LOW;
                    end else if (stall_s) begin
                        // ptr_r stays on the stalled owner so it ranks last next time.
                        if (timeout_s) begin
                            LOCKED <= 1'b0;
                            cnt_r  <= {CW{1'b0}};
                        end else begin
                            cnt_r  <= cnt_r + CW'(1'b1);
                        end
                    end else if (!LOCKED) begin
                        cnt_r <= {CW{1'b0}};
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!TX_RDY) begin
                        state_r <= ST_WAIT_HIGH;
                    end else begin
                        state_r <= ST_WAIT_LOW;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (TX_RDY) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_HIGH;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple usart model
// and per-requester message models.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int LT   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_rdy;
    logic [1:0]  owner;
    logic        locked;
    logic        busy;

    uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TIMEOUT(LT)) dut (
        .CLK50M   (clk),
        .RST      (rst),
        .REQ      (req),
        .REQ_LAST (req_last),
        .REQ_DATA (req_data),
        .REQ_ACK  (req_ack),
        .TX_DATA  (tx_data),
        .TX_WR    (tx_wr),
        .TX_RDY   (tx_rdy),
        .OWNER    (owner),
        .LOCKED   (locked),
        .BUSY     (busy)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Requester models: mode 0 = LAST on final byte, 1 = every byte LAST, 2 = never LAST.
    int msg_rem[4];
    int msg_mode[4];

    function automatic logic last_for(input int rem, input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        return (rem == 1);
    endfunction

    task automatic load_req(input int i, input int cnt, input logic [7:0] d, input int mode);
        msg_rem[i]         = cnt;
        msg_mode[i]        = mode;
        req_data[8*i +: 8] = d;
        req_last[i]        = last_for(cnt, mode);
        req[i]             = 1'b1;
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (req_ack[i] && msg_rem[i] > 0) begin
                msg_rem[i]--;
                if (msg_rem[i] == 0) begin
                    req[i]      = 1'b0;
                    req_last[i] = 1'b0;
                end else begin
                    req_data[8*i +: 8] = req_data[8*i +: 8] + 8'h01;
                    req_last[i]        = last_for(msg_rem[i], msg_mode[i]);
                end
            end
        end
    end

    // Usart model: Tx_RDY drops the cycle after the strobe and stays low 10 cycles.
    logic usart_en;
    int   u_cnt = 0;

    always @(negedge clk) begin
        if (usart_en) begin
            if (tx_wr) begin
                tx_rdy = 1'b0;
                u_cnt  = 10;
            end else if (u_cnt > 0) begin
                u_cnt--;
                if (u_cnt == 0) tx_rdy = 1'b1;
            end
        end
    end

    typedef struct {
        logic [3:0] ack;
        logic [7:0] data;
        logic       lck;
        int         cyc;
    } grant_t;
    grant_t glog[$];

    always @(negedge clk) begin
        if (tx_wr) glog.push_back('{req_ack, tx_data, locked, cyc});
    end

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((req != 4'b0000 || busy || !tx_rdy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val({"idle_", tag}, 32'(n < 2000), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        req      = 4'b0000;
        req_last = 4'b0000;
        for (int i = 0; i < 4; i++) msg_rem[i] = 0;
        @(negedge clk);
        rst = 1'b0;
        glog.delete();
    endtask

    task automatic check_grants(input string tag, input int n, input logic [19:0] e_ack,
                                input logic [39:0] e_data, input logic [4:0] e_lck);
        check_val({tag, "_count"}, 32'(glog.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (k < glog.size()) begin
                check_val($sformatf("%s_ack%0d", tag, k), 32'(glog[k].ack), 32'(e_ack[4*k +: 4]));
                check_val($sformatf("%s_dat%0d", tag, k), 32'(glog[k].data), 32'(e_data[8*k +: 8]));
                check_val($sformatf("%s_lck%0d", tag, k), 32'(glog[k].lck), 32'(e_lck[k]));
            end
        end
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int stall;
        int wr_seen;
        int min_gap;
        rst      = 1'b1;
        req      = 4'b0000;
        req_last = 4'b0000;
        req_data = 32'h0;
        tx_rdy   = 1'b1;
        usart_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            msg_rem[i]  = 0;
            msg_mode[i] = 0;
        end
        repeat (3) @(negedge clk);

        check_val("rst_data", 32'(tx_data), 32'h00);
        check_val("rst_wr", 32'(tx_wr), 32'd0);
        check_val("rst_ack", 32'(req_ack), 32'd0);
        check_val("rst_owner", 32'(owner), 32'd0);
        check_val("rst_locked", 32'(locked), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Single byte from requester 2
        @(negedge clk);
        load_req(2, 1, 8'hA5, 0);
        @(negedge clk);
        check_val("sb_wr", 32'(tx_wr), 32'd1);
        check_val("sb_ack", 32'(req_ack), 32'h4);
        check_val("sb_data", 32'(tx_data), 32'hA5);
        check_val("sb_owner", 32'(owner), 32'd2);
        check_val("sb_locked", 32'(locked), 32'd0);
        check_val("sb_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check_val("sb_wr_off", 32'(tx_wr), 32'd0);
        check_val("sb_ack_off", 32'(req_ack), 32'd0);
        wait_idle("sb");

        // Round-robin across all requesters
        do_reset();
        load_req(0, 2, 8'h10, 1);
        load_req(1, 1, 8'h20, 0);
        load_req(2, 1, 8'h30, 0);
        load_req(3, 1, 8'h40, 0);
        wait_idle("rr");
        check_grants("rr", 5, {4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001},
                     {8'h11, 8'h40, 8'h30, 8'h20, 8'h10}, 5'b00000);
        min_gap = 1000;
        for (int k = 1; k < glog.size(); k++) begin
            if (glog[k].cyc - glog[k-1].cyc < min_gap) min_gap = glog[k].cyc - glog[k-1].cyc;
        end
        check_val("rr_spacing", 32'(min_gap >= 3), 32'd1);

        // Message lock: requester 1 sends three bytes while 0 and 3 wait
        do_reset();
        load_req(0, 1, 8'h01, 0);
        wait_idle("lk_pre");
        glog.delete();
        load_req(1, 3, 8'h50, 0);
        load_req(0, 1, 8'h60, 0);
        load_req(3, 1, 8'h70, 0);
        wait_idle("lk");
        check_grants("lk", 5, {4'b0001, 4'b1000, 4'b0010, 4'b0010, 4'b0010},
                     {8'h60, 8'h70, 8'h52, 8'h51, 8'h50}, 5'b00011);

        // Lock timeout after a stalled owner
        do_reset();
        load_req(2, 1, 8'h33, 2);
        n = 0;
        while (!req_ack[2] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("to_ack_seen", 32'(req_ack[2]), 32'd1);
        check_val("to_locked", 32'(locked), 32'd1);
        load_req(0, 1, 8'h44, 0);
        stall = 0;
        n = 0;
        while (locked && n < 200) begin
            @(negedge clk);
            n++;
            if (!busy && locked) stall++;
        end
        check_val("to_stall", 32'(stall), 32'(LT));
        wait_idle("to");
        check_grants("to", 2, {12'h000, 4'b0001, 4'b0100},
                     {24'h0, 8'h44, 8'h33}, 5'b00001);

        // Reset during WAIT_HIGH, then grant held off while Tx_RDY is low
        do_reset();
        usart_en = 1'b0;
        tx_rdy   = 1'b1;
        load_req(1, 2, 8'h90, 0);
        @(negedge clk);
        check_val("rm_wr", 32'(tx_wr), 32'd1);
        check_val("rm_locked", 32'(locked), 32'd1);
        tx_rdy = 1'b0;
        @(negedge clk);
        check_val("rm_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("rm_data", 32'(tx_data), 32'h00);
        check_val("rm_wr0", 32'(tx_wr), 32'd0);
        check_val("rm_ack0", 32'(req_ack), 32'd0);
        check_val("rm_owner", 32'(owner), 32'd0);
        check_val("rm_locked0", 32'(locked), 32'd0);
        check_val("rm_busy0", 32'(busy), 32'd0);
        rst = 1'b0;
        load_req(0, 1, 8'hC3, 0);
        wr_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (tx_wr) wr_seen++;
        end
        check_val("rm_nowr", 32'(wr_seen), 32'd0);
        tx_rdy = 1'b1;
        @(negedge clk);
        check_val("rm_wr2", 32'(tx_wr), 32'd1);
        check_val("rm_ack2", 32'(req_ack), 32'h1);
        check_val("rm_data2", 32'(tx_data), 32'hC3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single usart transmit path between NREQ byte-stream requesters (command responder, status reporter, debug logger, …). It sits between the requesters and the usart instance, driving its DATA_IN and write strobe and watching Tx_RDY. It grants bytes round-robin but locks the channel to one requester for a whole message, so multi-byte messages never interleave on TxD. A lock timeout recovers the channel from a requester that stalls mid-message.

## Interface
- NREQ, 4: number of requesters (2..8); OWNER width is OW = clog2(NREQ).
- LOCK_TIMEOUT, 1024: idle cycles a locked owner may stall before its lock is dropped (≥1, counter width clog2(LOCK_TIMEOUT+1)).

Ports:
- CLK50M  in  1  system clock, 50 MHz.
- RST  in  1  synchronous reset, active-high.
- REQ  in  NREQ  requester i has a valid byte.
- REQ_LAST  in  NREQ  byte of requester i is the last of its message.
- REQ_DATA  in  8*NREQ  byte of requester i on bits [8i+7:8i].
- REQ_ACK  out  NREQ  one-cycle pulse: byte of requester i consumed.
- TX_DATA  out  8  byte to usart DATA_IN; held stable until next grant.
- TX_WR  out  1  one-cycle active-high write strobe to usart n_WR (the usart treats n_WR as active-high write enable).
- TX_RDY  in  1  usart Tx_RDY: high = transmitter idle, can accept a byte.
- OWNER  out  OW  index of last/current granted requester.
- LOCKED  out  1  channel reserved for OWNER until its message ends.
- BUSY  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, WAIT_LOW, WAIT_HIGH.
- IDLE, grant condition: TX_RDY = 1 and at least one eligible requester. Eligible = REQ[i] for all i when LOCKED = 0; only REQ[OWNER] when LOCKED = 1.
- Winner selection: round-robin, search starts at ptr+1 modulo NREQ, first eligible wins; ptr is set to the winner on each grant.
- On grant (single clock edge): TX_DATA ← REQ_DATA[winner]; TX_WR ← 1; REQ_ACK[winner] ← 1; OWNER ← winner; LOCKED ← ~REQ_LAST[winner]; timeout counter ← 0; state → WAIT_LOW.
- WAIT_LOW: stay until TX_RDY = 0, then → WAIT_HIGH. There is no timeout; the usart drops Tx_RDY the cycle after the strobe.
- WAIT_HIGH: stay until TX_RDY = 1, then → IDLE.
- Lock timeout: in IDLE with LOCKED = 1 and REQ[OWNER] = 0, the counter increments each cycle. When it reaches LOCK_TIMEOUT, LOCKED ← 0 and the counter clears. ptr stays at OWNER, so the stalled owner gets lowest priority next.
- Counter clears on any grant and whenever LOCKED = 0.
- Requesters hold REQ, REQ_LAST and REQ_DATA stable from assertion until they see REQ_ACK. A requester may present its next byte the cycle after ACK. No double-consume is possible, because the arbiter spends at least 2 cycles outside IDLE.
- REQ deasserted by a non-owner before its grant is legal and simply forfeits that turn.

## Timing
- Reset values (RST high at a CLK50M edge): state IDLE, TX_DATA 8'h00, TX_WR 0, REQ_ACK 0, OWNER 0, LOCKED 0, BUSY 0, counter 0, ptr NREQ-1 (requester 0 has top priority first).
- Grant latency: TX_WR and REQ_ACK assert on the edge after the grant condition is sampled true in IDLE. Both are high for exactly one cycle and coincide.
- Minimum grant-to-grant spacing is 3 cycles plus the usart frame time. The next grant needs TX_RDY seen low, then seen high again.
- Reset mid-operation: all state returns to reset values next edge. A byte already in the usart finishes on TxD. The next grant waits for TX_RDY = 1.
- The timeout and a new REQ[OWNER] in the same cycle resolve as a grant; the lock does not drop.
- Last byte of a message with other requesters pending: LOCKED falls with that grant, and the next IDLE arbitrates from OWNER+1.
- BUSY is combinational from state and rises the same edge TX_WR rises.

## Test plan
- Single byte: REQ[2] = 1, REQ_LAST[2] = 1, data 8'hA5, TX_RDY = 1 -> next edge TX_WR = 1, REQ_ACK = 4'b0100, TX_DATA = A5, OWNER = 2, LOCKED = 0. Both pulses last 1 cycle.
- Round-robin: REQ = 4'b1111, all single-byte, modelled usart (Tx_RDY low 10 cycles per byte) -> grant order 0, 1, 2, 3, 0. Grants never occur less than 3 cycles apart.
- Message lock: requester 1 sends 3 bytes (LAST on the third) while REQ[0] and REQ[3] are held -> TxD order is 1, 1, 1, then 3, then 0. LOCKED is high across the first two bytes.
- Lock timeout: LOCK_TIMEOUT = 16; requester 2 sends 1 non-last byte then drops REQ; REQ[0] pending -> LOCKED falls exactly 16 IDLE cycles later, and the next grant goes to requester 0.
- Reset mid-byte: assert RST during WAIT_HIGH with Tx_RDY low -> all outputs return to reset values next edge. No TX_WR occurs until Tx_RDY returns high; then requester 0 wins if pending.
- Tx_RDY low in IDLE with REQ pending -> no grant and TX_WR stays 0 until Tx_RDY rises; the grant follows on the next edge.
